truth_table_sequencer: RTL and testbench

//  Synthesizable stimulus/check stage for the 2-input gate blocks (nor_gate and siblings).
//  - Upstream role: steps the input vector through every combination, each held for a fixed number of cycles.
//  - Downstream role: samples the gate output y and compares it with an expected truth table.
//  - Reports pass/fail, the error count and the first failing vector.
//  - Lets gate checks run on hardware and in sim, without '#' delay-based benches.

---
 rtl/gate_check_pkg.sv | 18 +
 rtl/hold_timer.sv | 40 ++++
 rtl/truth_table_sequencer.sv | 127 ++++++++++++
 tb/tb_truth_table_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and reference truth tables for the 2-input gate checkers.
// Truth tables are indexed by input vector value: bit i is the expected y for vec == i,
// where vec = {a, b}.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } seq_state_t;

  localparam logic [3:0] NOR2_TT = 4'b0001;
  localparam logic [3:0] AND2_TT = 4'b1000;
  localparam logic [3:0] OR2_TT  = 4'b1110;
  localparam logic [3:0] XOR2_TT = 4'b0110;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times how long each vector is held.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (count -> 0)
//   load     load load_val this cycle (has priority over counting)
//   load_val value to load
//   zero     count is currently 0
// The counter stops at 0 rather than wrapping.
module hold_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Stimulus/check stage for 2-input gate blocks. Steps vec_out through every input
// combination, holds each for HOLD_CYCLES cycles, then samples y_in for one cycle and
// compares it against EXP_TABLE[vec_out]. Reports pass/fail, error count and the first
// failing vector.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       pulse; starts (or restarts) a run from IDLE or DONE, ignored while busy
//   vec_out     gate inputs, {a, b} with a as MSB
//   y_in        gate output under test (only looked at in SAMPLE)
//   busy        run in progress (DRIVE or SAMPLE)
//   done        run complete, held until next start or rst
//   pass        done and no mismatches
//   err_count   mismatching vectors this run
//   fail_valid  a mismatch has been recorded; fail_vec holds the first one
// HOLD_CYCLES must be >= 1.
module truth_table_sequencer
  import gate_check_pkg::*;
#(
  parameter int unsigned         N_IN        = 2,
  parameter int unsigned         HOLD_CYCLES = 10,
  parameter logic [2**N_IN-1:0]  EXP_TABLE   = NOR2_TT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int unsigned     CntW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] HoldInit = CntW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LastVec  = '1;

  seq_state_t      state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fvalid_q, fvalid_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            hold_load;
  logic            hold_zero;

  hold_timer #(
    .Width(CntW)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .load_val(HoldInit),
    .zero    (hold_zero)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    err_d     = err_q;
    fvalid_d  = fvalid_q;
    fvec_d    = fvec_q;
    hold_load = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          vec_d     = '0;
          err_d     = '0;
          fvalid_d  = 1'b0;
          fvec_d    = '0;
          hold_load = 1'b1;
        end
      end
      DRIVE: begin
        if (hold_zero) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // err_count is one bit wider than vec, so it cannot overflow within a run.
        if (y_in != EXP_TABLE[vec_q]) begin
          err_d = err_q + (N_IN + 1)'(1);
          if (!fvalid_q) begin
            fvalid_d = 1'b1;
            fvec_d   = vec_q;
          end
        end
        if (vec_q == LastVec) begin
          state_d = DONE;
        end else begin
          state_d   = DRIVE;
          vec_d     = vec_q + N_IN'(1);
          hold_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign pass       = (state_q == DONE) && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer. Three instances share clock and reset:
//   dut_a: NOR2 table, HOLD 10, driven by an inline NOR (optionally stuck-at-0 / X outside SAMPLE)
//   dut_b: wrong table 4'b0011, correct NOR
//   dut_c: NOR2 table, HOLD 1, y stuck-at-1
module tb_truth_table_sequencer;
  import gate_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, start_c;
  logic       stuck0, xmode;
  logic       y_a, y_b, y_c;
  logic [1:0] vec_a, vec_b, vec_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c;
  logic [2:0] err_a, err_b, err_c;
  logic       fv_a, fv_b, fv_c;
  logic [1:0] fvec_a, fvec_b, fvec_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Inline NOR gate under test: a = vec[1], b = vec[0].
  assign y_a = xmode ? 1'bx : (stuck0 ? 1'b0 : ~(vec_a[1] | vec_a[0]));
  assign y_b = ~(vec_b[1] | vec_b[0]);
  assign y_c = 1'b1;

  truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(10), .EXP_TABLE(NOR2_TT)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .y_in(y_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(10), .EXP_TABLE(4'b0011)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .y_in(y_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .EXP_TABLE(NOR2_TT)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .vec_out(vec_c), .y_in(y_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .fail_valid(fv_c), .fail_vec(fvec_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full 44-cycle run of dut_a. Extra start pulses at cycles p1/p2 (0 = none);
  // xm drives y_a to X whenever the DUT is not in SAMPLE; chk_c also checks dut_c's
  // 8-cycle run that was started on the same edge.
  task automatic run_a(input int p1, input int p2, input bit xm, input bit chk_c);
    logic [1:0] ev;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    chk("first_cycle_busy", 32'(busy_a), 32'd1);
    chk("first_cycle_done", 32'(done_a), 32'd0);
    chk("first_cycle_vec", 32'(vec_a), 32'd0);
    xmode = xm;
    for (int c = 1; c <= 44; c++) begin
      start_a = (c == p1) || (c == p2);
      tick();
      start_a = 1'b0;
      // After edge c, DUT is in SAMPLE iff c % 11 == 10.
      xmode = xm && ((c % 11) != 10) && (c < 44);
      ev = (c >= 44) ? 2'd3 : 2'(c / 11);
      chk($sformatf("vec_c%0d", c), 32'(vec_a), 32'(ev));
      chk($sformatf("busy_c%0d", c), 32'(busy_a), 32'(c < 44));
      chk($sformatf("done_c%0d", c), 32'(done_a), 32'(c == 44));
      if (chk_c && (c == 7 || c == 8)) begin
        chk($sformatf("h1_done_c%0d", c), 32'(done_c), 32'(c == 8));
      end
    end
    xmode = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    stuck0  = 1'b0;
    xmode   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset_outputs", 32'({vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}), 32'd0);
    tick();
    chk("idle_no_start", 32'({busy_a, done_a}), 32'd0);

    // T1 golden run, with T2 (dut_b) and T6 (dut_c) started on the same edge
    start_b = 1'b1;
    start_c = 1'b1;
    run_a(0, 0, 1'b0, 1'b1);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_err", 32'(err_a), 32'd0);
    chk("t1_fvalid", 32'(fv_a), 32'd0);
    chk("t2_err", 32'(err_b), 32'd1);
    chk("t2_fvec", 32'(fvec_b), 32'd1);
    chk("t2_pass", 32'(pass_b), 32'd0);
    chk("t2_done", 32'(done_b), 32'd1);
    chk("t6_err", 32'(err_c), 32'd3);
    chk("t6_fvec", 32'(fvec_c), 32'd1);
    chk("t6_fvalid", 32'(fv_c), 32'd1);
    chk("t6_pass", 32'(pass_c), 32'd0);
    chk("t6_vec_nowrap", 32'(vec_c), 32'd3);
    chk("busy_done_exclusive", 32'(busy_c & done_c), 32'd0);

    // T5: restart from DONE, stray starts mid-run, y_in X outside SAMPLE
    run_a(5, 30, 1'b1, 1'b0);
    chk("t5_pass", 32'(pass_a), 32'd1);
    chk("t5_err", 32'(err_a), 32'd0);

    // T3: stuck-at-0 y_in
    stuck0 = 1'b1;
    run_a(0, 0, 1'b0, 1'b0);
    stuck0 = 1'b0;
    chk("t3_err", 32'(err_a), 32'd1);
    chk("t3_fvec", 32'(fvec_a), 32'd0);
    chk("t3_fvalid", 32'(fv_a), 32'd1);
    chk("t3_pass", 32'(pass_a), 32'd0);

    // T4: reset at cycle 20, with start asserted alongside (rst wins)
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (19) tick();
    chk("t4_midrun_busy", 32'(busy_a), 32'd1);
    rst     = 1'b1;
    start_a = 1'b1;
    tick();
    rst     = 1'b0;
    start_a = 1'b0;
    chk("t4_reset_outputs", 32'({vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}), 32'd0);
    tick();
    chk("t4_still_idle", 32'({busy_a, done_a}), 32'd0);
    run_a(0, 0, 1'b0, 1'b0);
    chk("t4_rerun_pass", 32'(pass_a), 32'd1);
    chk("t4_rerun_err", 32'(err_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
